regfile_wr_arbiter: RTL and testbench

- Shares the single register-file write port between two writeback requesters: A is the single-cycle ALU path, B is the multi-cycle load/mul-div path.
- Drives the 32 per-register enable lines and the common write-data bus of the 32x32 regfile built from enable-and-clear 32-bit flop registers.
- Keeps a pending-write scoreboard that decode uses for hazard stalls.
- Sits between the writeback stage and the regfile.

---
 rtl/regfile_pkg.sv | 19 +
 rtl/regfile_wdec.sv | 22 ++
 rtl/regfile_wr_arbiter.sv | 99 +++++++++
 tb/tb_regfile_wr_arbiter.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared constants and types for the register-file write-port arbiter.
package regfile_pkg;

    localparam int unsigned RF_AW   = 5;
    localparam int unsigned RF_DW   = 32;
    localparam int unsigned RF_NREG = 1 << RF_AW;
    localparam int unsigned R0_IDX  = 0;

    // Requester identity; also the round-robin pointer encoding.
    typedef enum logic {
        REQ_A = 1'b0,
        REQ_B = 1'b1
    } req_e;

    function automatic req_e other_req(input req_e r);
        return (r == REQ_A) ? REQ_B : REQ_A;
    endfunction

endpackage

// File: rtl/regfile_wdec.sv
// AW-to-NREG one-hot decoder with enable and optional r0 suppression.
module regfile_wdec
    import regfile_pkg::*;
#(
    parameter int unsigned AW           = RF_AW,
    parameter int unsigned NREG         = RF_NREG,
    parameter int unsigned R0_HARDWIRED = 1
) (
    input  logic            en,
    input  logic [AW-1:0]   addr,
    output logic [NREG-1:0] onehot
);

    // Compare the address against every register index; r0 never decodes when hardwired.
    always_comb begin
        onehot = '0;
        for (int unsigned i = 0; i < NREG; i++) begin
            onehot[i] = en && (addr == AW'(i)) && !((R0_HARDWIRED != 0) && (i == R0_IDX));
        end
    end

endmodule

// File: rtl/regfile_wr_arbiter.sv
// Two-requester round-robin arbiter for the single regfile write port,
// with registered one-hot enables, write data and a pending-write scoreboard.
module regfile_wr_arbiter
    import regfile_pkg::*;
#(
    parameter int unsigned AW           = RF_AW,
    parameter int unsigned DW           = RF_DW,
    parameter int unsigned NREG         = RF_NREG,
    parameter int unsigned R0_HARDWIRED = 1
) (
    input  logic            Clk,
    input  logic            Clr,
    input  logic            ReqA,
    input  logic [AW-1:0]   AddrA,
    input  logic [DW-1:0]   DataA,
    output logic            AckA,
    input  logic            ReqB,
    input  logic [AW-1:0]   AddrB,
    input  logic [DW-1:0]   DataB,
    output logic            AckB,
    input  logic            Resv,
    input  logic [AW-1:0]   ResvAddr,
    output logic [NREG-1:0] We,
    output logic [DW-1:0]   Wd,
    output logic [NREG-1:0] Pend
);

    req_e            ptr;
    logic            gnt_any;
    req_e            gnt_who;
    logic [AW-1:0]   gnt_addr;
    logic [DW-1:0]   gnt_data;
    logic [NREG-1:0] we_next;
    logic [NREG-1:0] pend_set;

    // Grant selection: a lone requester wins, the pointer breaks ties; nothing while in reset.
    always_comb begin
        AckA     = 1'b0;
        AckB     = 1'b0;
        gnt_any  = 1'b0;
        gnt_who  = REQ_A;
        gnt_addr = '0;
        gnt_data = '0;
        if (!Clr) begin
            if (ReqA && (!ReqB || ptr == REQ_A)) begin
                AckA     = 1'b1;
                gnt_any  = 1'b1;
                gnt_who  = REQ_A;
                gnt_addr = AddrA;
                gnt_data = DataA;
            end else if (ReqB) begin
                AckB     = 1'b1;
                gnt_any  = 1'b1;
                gnt_who  = REQ_B;
                gnt_addr = AddrB;
                gnt_data = DataB;
            end
        end
    end

    regfile_wdec #(
        .AW          (AW),
        .NREG        (NREG),
        .R0_HARDWIRED(R0_HARDWIRED)
    ) u_we_dec (
        .en    (gnt_any),
        .addr  (gnt_addr),
        .onehot(we_next)
    );

    regfile_wdec #(
        .AW          (AW),
        .NREG        (NREG),
        .R0_HARDWIRED(R0_HARDWIRED)
    ) u_resv_dec (
        .en    (Resv),
        .addr  (ResvAddr),
        .onehot(pend_set)
    );

    // Register the write port, advance the pointer past the winner, and update the scoreboard.
    always_ff @(posedge Clk or posedge Clr) begin
        if (Clr) begin
            ptr  <= REQ_A;
            We   <= '0;
            Wd   <= '0;
            Pend <= '0;
        end else begin
            We <= we_next;
            if (gnt_any) begin
                Wd  <= gnt_data;
                ptr <= other_req(gnt_who);
            end
            // A new reservation landing on the commit edge must survive the clear.
            Pend <= (Pend & ~We) | pend_set;
        end
    end

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Randomized self-checking bench for regfile_wr_arbiter with a behavioural model.
module tb_regfile_wr_arbiter;

    logic        Clk = 1'b0;
    logic        Clr;
    logic        ReqA, ReqB, Resv;
    logic [4:0]  AddrA, AddrB, ResvAddr;
    logic [31:0] DataA, DataB;
    logic        AckA, AckB;
    logic [31:0] We, Wd, Pend;

    int unsigned checks = 0;
    int unsigned errors = 0;

    // Behavioural model state: what the registered outputs should hold right now.
    logic [31:0] m_we, m_wd, m_pend;
    int          m_ptr;   // 0 = A has priority on a tie, 1 = B
    logic        m_ga, m_gb;
    logic        s_acka, s_ackb;

    regfile_wr_arbiter #(
        .AW(5), .DW(32), .NREG(32), .R0_HARDWIRED(1)
    ) dut (
        .Clk(Clk), .Clr(Clr),
        .ReqA(ReqA), .AddrA(AddrA), .DataA(DataA), .AckA(AckA),
        .ReqB(ReqB), .AddrB(AddrB), .DataB(DataB), .AckB(AckB),
        .Resv(Resv), .ResvAddr(ResvAddr),
        .We(We), .Wd(Wd), .Pend(Pend)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_we = '0; m_wd = '0; m_pend = '0; m_ptr = 0;
    endtask

    task automatic idle_inputs();
        ReqA = 0; ReqB = 0; Resv = 0;
        AddrA = '0; AddrB = '0; ResvAddr = '0; DataA = '0; DataB = '0;
    endtask

    // One clock cycle: inputs are set at the falling edge before the call; returns at the next falling edge.
    task automatic step();
        logic        ga, gb;
        logic [31:0] nwe, setm;
        #1;
        chk("we", We, m_we);
        chk("wd", Wd, m_wd);
        chk("pend", Pend, m_pend);
        ga = ReqA && (!ReqB || m_ptr == 0);
        gb = ReqB && (!ReqA || m_ptr == 1);
        chk("acka", AckA, ga);
        chk("ackb", AckB, gb);
        s_acka = AckA; s_ackb = AckB;
        m_ga = ga; m_gb = gb;
        nwe = 0;
        if (ga && AddrA != 0) nwe = 32'd1 << AddrA;
        if (gb && AddrB != 0) nwe = 32'd1 << AddrB;
        setm = (Resv && ResvAddr != 0) ? (32'd1 << ResvAddr) : 32'd0;
        @(posedge Clk);
        m_pend = (m_pend & ~m_we) | setm;
        m_we = nwe;
        if (ga) begin m_wd = DataA; m_ptr = 1; end
        if (gb) begin m_wd = DataB; m_ptr = 0; end
        @(negedge Clk);
    endtask

    initial begin
        idle_inputs();
        Clr = 1'b1;
        model_reset();
        #2;
        chk("rst_we", We, 0);
        chk("rst_wd", Wd, 0);
        chk("rst_pend", Pend, 0);
        chk("rst_acka", AckA, 0);
        @(negedge Clk); @(negedge Clk);
        Clr = 1'b0;

        // Single A write to r3.
        ReqA = 1; AddrA = 5'd3; DataA = 32'hDEADBEEF;
        step();
        chk("a3_ack", s_acka, 1);
        idle_inputs();
        chk("a3_we", We, 32'h8);
        chk("a3_wd", Wd, 32'hDEADBEEF);
        step();
        chk("a3_we_off", We, 0);
        chk("a3_wd_hold", Wd, 32'hDEADBEEF);

        // Reserve r7, commit it three cycles later.
        Resv = 1; ResvAddr = 5'd7;
        step();
        idle_inputs();
        chk("r7_pend", Pend, 32'h80);
        step(); step();
        ReqA = 1; AddrA = 5'd7; DataA = 32'h0000_0777;
        step();
        idle_inputs();
        chk("r7_we", We, 32'h80);
        chk("r7_pend_hold", Pend, 32'h80);
        step();
        chk("r7_pend_clr", Pend, 0);

        // Reservation of r9 on the same edge that commits r9.
        ReqA = 1; AddrA = 5'd9; DataA = 32'h99; Resv = 1; ResvAddr = 5'd9;
        step();
        ReqA = 0;
        chk("r9_we", We, 32'h200);
        step();
        idle_inputs();
        chk("r9_setwins", Pend[9], 1);

        // B writes r0: acked, never enabled, never pending.
        ReqB = 1; AddrB = 5'd0; DataB = 32'h12345678;
        Resv = 1; ResvAddr = 5'd0;
        step();
        chk("b0_ack", s_ackb, 1);
        idle_inputs();
        chk("b0_we", We, 0);
        chk("b0_pend0", Pend[0], 0);
        step();
        chk("b0_we2", We, 0);

        // Build up state, then assert reset in the middle of a cycle with A requesting r5.
        ReqB = 1; AddrB = 5'd4; DataB = 32'hCAFE; Resv = 1; ResvAddr = 5'd12;
        step();
        idle_inputs();
        ReqA = 1; AddrA = 5'd5; DataA = 32'h55;
        #3;
        Clr = 1'b1;
        #1;
        chk("clr_acka", AckA, 0);
        chk("clr_we", We, 0);
        chk("clr_wd", Wd, 0);
        chk("clr_pend", Pend, 0);
        model_reset();
        @(posedge Clk);
        @(negedge Clk);
        chk("clr_hold_we", We, 0);
        Clr = 1'b0;

        // Both requesters held: grants alternate starting with A.
        ReqA = 1; AddrA = 5'd1; DataA = 32'hA1;
        ReqB = 1; AddrB = 5'd2; DataB = 32'hB2;
        for (int k = 0; k < 4; k++) begin
            step();
            chk("rr_acka", s_acka, (k % 2) == 0);
            chk("rr_we", We, (k % 2) == 0 ? 32'h2 : 32'h4);
        end
        idle_inputs();
        step();

        // Randomized traffic: requesters hold until acked, decode reserves at random.
        for (int n = 0; n < 500; n++) begin
            if (!ReqA && ($urandom % 2 == 0)) begin
                ReqA = 1; AddrA = 5'($urandom); DataA = $urandom;
            end
            if (!ReqB && ($urandom % 3 == 0)) begin
                ReqB = 1; AddrB = 5'($urandom); DataB = $urandom;
            end
            Resv = ($urandom % 4 == 0);
            ResvAddr = 5'($urandom);
            step();
            if (m_ga) ReqA = 0;
            if (m_gb) ReqB = 0;
        end
        idle_inputs();
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
